// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// funct3 op codes, FSM state encoding and operand-signedness helpers.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'b000,
    MULDIV_MULH   = 3'b001,
    MULDIV_MULHSU = 3'b010,
    MULDIV_MULHU  = 3'b011,
    MULDIV_DIV    = 3'b100,
    MULDIV_DIVU   = 3'b101,
    MULDIV_REM    = 3'b110,
    MULDIV_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiplier or restoring divider on unsigned
// magnitudes, one step per cycle over a 2N-bit {hi,lo} register pair.
module muldiv_iter_core #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode_i,   // 0: multiply, 1: divide
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N-1:0]   opa_i,
  input  logic [N-1:0]   opb_i,
  output logic [2*N-1:0] acc_o
);

  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;
  logic [N-1:0] m_q, m_d;
  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N:0]   trial;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    sum     = {1'b0, hi_q} + {1'b0, m_q};
    shifted = {hi_q, lo_q[N-1]};
    trial   = shifted - {1'b0, m_q};
    if (load_i) begin
      hi_d = '0;
      if (mode_i) begin
        lo_d = opa_i;
        m_d  = opb_i;
      end else begin
        lo_d = opb_i;
        m_d  = opa_i;
      end
    end else if (step_i) begin
      if (mode_i) begin
        // hi < divisor always holds, so trial[N] set means the subtract underflowed
        if (!trial[N]) begin
          hi_d = trial[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b1};
        end else begin
          hi_d = shifted[N-1:0];
          lo_d = {lo_q[N-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {sum, lo_q[N-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[N-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign acc_o = {hi_q, lo_q};

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: operand latch, iteration
// counter, FSM control and final sign correction around muldiv_iter_core.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   op,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             negq_q, negq_d;
  logic             nega_q, nega_d;
  logic             special_q, special_d;
  logic [N-1:0]     spec_q, spec_d;
  logic [N-1:0]     result_q, result_d;

  logic             sa, sb;
  logic [N-1:0]     a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [N-1:0]     spec_res;
  logic             core_mode, core_load, core_step;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   prod_s;
  logic [N-1:0]     quot_s, rem_s;
  logic [N-1:0]     fixed_res;

  always_comb begin
    sa       = op_a_signed(op) & rs1[N-1];
    sb       = op_b_signed(op) & rs2[N-1];
    a_mag    = sa ? -rs1 : rs1;
    b_mag    = sb ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    div_ovf  = ((op == MULDIV_DIV) || (op == MULDIV_REM)) &&
               (rs1 == {1'b1, {(N-1){1'b0}}}) && (rs2 == '1);
    if (div_zero) spec_res = op_is_rem(op) ? rs1 : '1;
    else          spec_res = op_is_rem(op) ? '0 : rs1;
  end

  // The core latches operands during the IDLE accept, before op_q is valid
  assign core_mode = (state_q == ST_IDLE) ? op_is_div(op) : op_is_div(op_q);

  muldiv_iter_core #(
    .N(N)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .mode_i(core_mode),
    .load_i(core_load),
    .step_i(core_step),
    .opa_i (a_mag),
    .opb_i (b_mag),
    .acc_o (acc)
  );

  always_comb begin
    prod_s = negq_q ? -acc : acc;
    quot_s = negq_q ? -acc[N-1:0] : acc[N-1:0];
    rem_s  = nega_q ? -acc[2*N-1:N] : acc[2*N-1:N];
    unique case (op_q)
      MULDIV_MUL:                              fixed_res = prod_s[N-1:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fixed_res = prod_s[2*N-1:N];
      MULDIV_DIV, MULDIV_DIVU:                 fixed_res = quot_s;
      default:                                 fixed_res = rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    negq_d    = negq_q;
    nega_d    = nega_q;
    special_d = special_q;
    spec_d    = spec_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          negq_d = sa ^ sb;
          nega_d = sa;
          if (op_is_div(op) && (div_zero || div_ovf)) begin
            special_d = 1'b1;
            spec_d    = spec_res;
            state_d   = ST_FIX;
          end else begin
            special_d = 1'b0;
            core_load = 1'b1;
            cnt_d     = CNT_W'(N);
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = special_q ? spec_q : fixed_res;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      core_load = 1'b0;
      core_step = 1'b0;
      result_d  = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      negq_q    <= 1'b0;
      nega_q    <= 1'b0;
      special_q <= 1'b0;
      spec_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      negq_q    <= negq_d;
      nega_q    <= nega_d;
      special_q <= special_d;
      spec_q    <= spec_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, hand-written
// flush/re-start/reset sequences and random ops against an arithmetic model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [N-1:0] rs1, rs2, result;
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.N(N), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .op    (op),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      MULDIV_MUL:    begin p = 64'(sa * sb); r = p[31:0]; end
      MULDIV_MULH:   begin p = 64'(sa * sb); r = p[63:32]; end
      MULDIV_MULHSU: begin p = 64'(sa * ub); r = p[63:32]; end
      MULDIV_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      MULDIV_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == '1) r = a;
        else r = 32'(ia / ib);
      end
      MULDIV_DIVU: r = (b == 0) ? '1 : a / b;
      MULDIV_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == '1) r = '0;
        else r = 32'(ia % ib);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o[2] && b == 0) return 2;
    if ((o == MULDIV_DIV || o == MULDIV_REM) && a == 32'h8000_0000 && b == '1) return 2;
    return N + 2;
  endfunction

  // Issues one op; cycle 1 is the first cycle after the accepting edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int done_cyc, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    done_cyc = -1;
    busy_cyc = 0;
    res      = 'x;
    for (int c = 1; c <= 60; c++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = c;
        res      = result;
        check("busy_low_in_done", {63'b0, busy}, 64'd0);
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done within 60 cycles");
    end
  endtask

  vec_t        vecs[13];
  logic [31:0] res;
  int          dc, bc, ndone, first_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[2]  = '{MULDIV_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[3]  = '{MULDIV_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[4]  = '{MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{MULDIV_DIVU,   32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{MULDIV_REMU,   32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{MULDIV_REM,    32'd5,          32'd0,         32'd5,         2};
    vecs[10] = '{MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
    vecs[12] = '{MULDIV_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {63'b0, busy}, 64'd0);
    check("reset_done",   {63'b0, done}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, dc, bc);
      check($sformatf("vec%0d_result", i), {32'b0, res}, {32'b0, vecs[i].exp});
      check($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].lat - 1));
    end

    // flush mid-divide: result keeps 14 from the prior DIVU
    run_op(MULDIV_DIVU, 32'd100, 32'd7, res, dc, bc);
    @(negedge clk);
    start = 1'b1; op = MULDIV_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", {63'b0, busy}, 64'd0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_result_kept", {32'b0, result}, 64'd14);
    run_op(MULDIV_MUL, 32'd3, 32'd4, res, dc, bc);
    check("mul_after_flush", {32'b0, res}, 64'd12);

    // start and flush together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MULDIV_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {63'b0, busy}, 64'd0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("start_flush_no_done", 64'(ndone), 64'd0);
    check("start_flush_result", {32'b0, result}, 64'd12);

    // start re-pulsed at cycles 5 and 34 (DONE) is ignored
    @(negedge clk);
    start = 1'b1; op = MULDIV_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first_done = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      start = (c == 5 || c == 34);
      op = MULDIV_MUL; rs1 = 32'd3; rs2 = 32'd3;
      @(negedge clk);
    end
    start = 1'b0;
    check("restart_one_done", 64'(ndone), 64'd1);
    check("restart_done_cycle", 64'(first_done), 64'd34);
    check("restart_result", {32'b0, result}, 64'd14);
    check("restart_idle", {63'b0, busy}, 64'd0);

    // asynchronous reset mid-op
    @(negedge clk);
    start = 1'b1; op = MULDIV_MUL; rs1 = 32'd5; rs2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy",   {63'b0, busy}, 64'd0);
    check("async_rst_done",   {63'b0, done}, 64'd0);
    check("async_rst_result", {32'b0, result}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(ndone), 64'd0);

    // randomized ops against the arithmetic model
    for (int k = 0; k < 200; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = '1; end
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        4: rb = '1;
        default: ;
      endcase
      run_op(ro, ra, rb, res, dc, bc);
      check($sformatf("rand%0d_op%0d_%h_%h", k, ro, ra, rb), {32'b0, res},
            {32'b0, ref_model(ro, ra, rb)});
      check($sformatf("rand%0d_latency", k), 64'(dc), 64'(ref_latency(ro, ra, rb)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
